// File: rtl/ps2_rx_decoder_pkg.sv
// Shared keyboard-path definitions: receive FSM encoding, prefix scan codes,
// frame geometry and the odd-parity helper.
package ps2_rx_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    LOAD = 2'd2
  } rx_state_t;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam int         FRAME_BITS = 11;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, a FILTER_LEN
// sample glitch filter on the clock, and a one-cycle falling-edge pulse.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2c_filt,
  output logic fall_edge,
  output logic ps2d_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync;
  logic [1:0]    d_sync;
  logic [CW-1:0] cnt;

  // Lines idle high, so synchronisers and filter come out of reset high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      cnt       <= '0;
      ps2c_filt <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c};
      d_sync    <= {d_sync[0], ps2d};
      fall_edge <= 1'b0;
      if (c_sync[1] == ps2c_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        ps2c_filt <= c_sync[1];
        cnt       <= '0;
        fall_edge <= ~c_sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 receive deframer: 11-bit frames to scan-code bytes with break/extended
// prefix flags. Build with PS2_PARITY_CHECK_EN to reject bytes on bad parity.
module ps2_rx_decoder
  import ps2_rx_decoder_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_code,
  output logic       ready,
  output logic       brk_code,
  output logic       ext_code,
  output logic       frame_err,
  output rx_state_t  fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          ps2c_filt;
  logic          fall_edge;
  logic          ps2d_sync;
  rx_state_t     state;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] tmo_cnt;
  logic          clr_pend;
  logic          byte_ok;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2c_filt (ps2c_filt),
    .fall_edge (fall_edge),
    .ps2d_sync (ps2d_sync)
  );

  // shift[7:0] = data, shift[8] = parity, shift[9] = stop once the frame is in.
`ifdef PS2_PARITY_CHECK_EN
  assign byte_ok = shift[9] && odd_parity_ok(shift[8:0]);
`else
  assign byte_ok = shift[9];
`endif

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tmo_cnt   <= '0;
      scan_code <= 8'h00;
      ready     <= 1'b0;
      brk_code  <= 1'b0;
      ext_code  <= 1'b0;
      frame_err <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      clr_pend  <= 1'b0;
      // Flags survive through the ready cycle of the first non-prefix byte.
      if (clr_pend) begin
        brk_code <= 1'b0;
        ext_code <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (fall_edge && rx_en && !ps2d_sync) begin
            state   <= RX;
            bit_cnt <= 4'd9;
            tmo_cnt <= '0;
          end
        end
        RX: begin
          if (fall_edge) begin
            shift   <= {ps2d_sync, shift[9:1]};
            bit_cnt <= bit_cnt - 1'b1;
            tmo_cnt <= '0;
            if (bit_cnt == 4'd0) state <= LOAD;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
          if (byte_ok) begin
            scan_code <= shift[7:0];
            ready     <= 1'b1;
            if (shift[7:0] == SC_BREAK)    brk_code <= 1'b1;
            else if (shift[7:0] == SC_EXT) ext_code <= 1'b1;
            else                           clr_pend <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: frames, prefixes, parity/stop errors,
// timeout, clock glitches and mid-frame reset.
module tb_ps2_rx_decoder;
  import ps2_rx_decoder_pkg::*;

  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] scan_code;
  logic       ready;
  logic       brk_code;
  logic       ext_code;
  logic       frame_err;
  rx_state_t  fsm_state;

  int tests = 0;
  int failed = 0;

  // Monitor state, sampled on the falling clock edge.
  int         rdy_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         fe_cnt = 0;
  int         cyc = 0;
  int         last_fe_cyc = 0;
  int         last_lat = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;
  logic       post_brk = 1'b0;
  logic       post_ext = 1'b0;
  logic       ready_d = 1'b0;

  ps2_rx_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .scan_code (scan_code),
    .ready     (ready),
    .brk_code  (brk_code),
    .ext_code  (ext_code),
    .frame_err (frame_err),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ready_d) begin
      post_brk = brk_code;
      post_ext = ext_code;
    end
    ready_d = ready;
    if (dut.fall_edge) begin
      fe_cnt      = fe_cnt + 1;
      last_fe_cyc = cyc;
    end
    if (ready) begin
      rdy_cnt   = rdy_cnt + 1;
      last_code = scan_code;
      last_brk  = brk_code;
      last_ext  = ext_code;
      last_lat  = cyc - last_fe_cyc;
      if (frame_err) both_cnt = both_cnt + 1;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rdy_cnt = 0;
    err_cnt = 0;
    fe_cnt  = 0;
  endtask

  // Frame bits go out LSB first: start, d0..d7, parity, stop.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = fr[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop_b);
    logic [10:0] fr;
    fr = {stop_b, (~^b) ^ flip, b, 1'b0};
    send_bits(fr, 11);
    ps2d = 1'b1;
    wait_cyc(40);
  endtask

  initial begin
    logic [10:0] part;

    // Reset state
    wait_cyc(5);
    chk("rst_scan_code", 32'(scan_code), 32'h00);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_brk", 32'(brk_code), 0);
    chk("rst_ext", 32'(ext_code), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b0;
    wait_cyc(20);

    // Plain 0x1C
    clr_mon();
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("1c_ready_cnt", 32'(rdy_cnt), 1);
    chk("1c_code", 32'(last_code), 32'h1C);
    chk("1c_brk", 32'(last_brk), 0);
    chk("1c_ext", 32'(last_ext), 0);
    chk("1c_err_cnt", 32'(err_cnt), 0);
    chk("1c_latency", 32'(last_lat), 2);
    chk("1c_fall_edges", 32'(fe_cnt), 11);

    // Break: F0 then 1C
    clr_mon();
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("f0_code", 32'(last_code), 32'hF0);
    chk("f0_brk", 32'(last_brk), 1);
    chk("f0_brk_held", 32'(brk_code), 1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("brk1c_ready_cnt", 32'(rdy_cnt), 2);
    chk("brk1c_code", 32'(last_code), 32'h1C);
    chk("brk1c_brk", 32'(last_brk), 1);
    chk("brk1c_post_brk", 32'(post_brk), 0);

    // Extended break: E0, F0, 75
    clr_mon();
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("e0_ext", 32'(last_ext), 1);
    chk("e0_brk", 32'(last_brk), 0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("e0f075_ready_cnt", 32'(rdy_cnt), 3);
    chk("e0f075_code", 32'(last_code), 32'h75);
    chk("e0f075_brk", 32'(last_brk), 1);
    chk("e0f075_ext", 32'(last_ext), 1);
    chk("e0f075_post_brk", 32'(post_brk), 0);
    chk("e0f075_post_ext", 32'(post_ext), 0);

    // Flipped parity on 0x1C
    clr_mon();
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err_cnt", 32'(err_cnt), 1);
    chk("par_ready_cnt", 32'(rdy_cnt), 0);
    chk("par_code_held", 32'(scan_code), 32'h75);
`else
    chk("par_err_cnt", 32'(err_cnt), 0);
    chk("par_ready_cnt", 32'(rdy_cnt), 1);
    chk("par_code", 32'(scan_code), 32'h1C);
`endif

    // Bad stop bit on 0x2D
    clr_mon();
    send_frame(8'h2D, 1'b0, 1'b0);
    chk("stop_err_cnt", 32'(err_cnt), 1);
    chk("stop_ready_cnt", 32'(rdy_cnt), 0);
    chk("stop_state", 32'(fsm_state), 32'(IDLE));

    // Frame with rx_en low is ignored
    clr_mon();
    rx_en = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1);
    rx_en = 1'b1;
    chk("rxen_ready_cnt", 32'(rdy_cnt), 0);
    chk("rxen_err_cnt", 32'(err_cnt), 0);
    chk("rxen_state", 32'(fsm_state), 32'(IDLE));

    // Timeout after 5 bits, then a clean 0x2D
    clr_mon();
    part = {1'b1, ~^8'h4A, 8'h4A, 1'b0};
    send_bits(part, 5);
    ps2d = 1'b1;
    chk("tmo_in_rx", 32'(fsm_state), 32'(RX));
    wait_cyc(TMO + 100);
    chk("tmo_err_cnt", 32'(err_cnt), 1);
    chk("tmo_ready_cnt", 32'(rdy_cnt), 0);
    chk("tmo_state", 32'(fsm_state), 32'(IDLE));
    send_frame(8'h2D, 1'b0, 1'b1);
    chk("tmo2d_ready_cnt", 32'(rdy_cnt), 1);
    chk("tmo2d_code", 32'(last_code), 32'h2D);

    // 2-cycle glitches on ps2c with data low (would look like a start bit)
    clr_mon();
    ps2d = 1'b0;
    wait_cyc(10);
    for (int g = 0; g < 6; g++) begin
      ps2c = 1'b0;
      wait_cyc(2);
      ps2c = 1'b1;
      wait_cyc(6);
    end
    wait_cyc(20);
    chk("glitch_fall_edges", 32'(fe_cnt), 0);
    chk("glitch_state", 32'(fsm_state), 32'(IDLE));
    ps2d = 1'b1;
    wait_cyc(20);

    // Reset mid-frame with brk_code set
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("prerst_brk", 32'(brk_code), 1);
    send_bits(part, 5);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_scan_code", 32'(scan_code), 32'h00);
    chk("midrst_brk", 32'(brk_code), 0);
    chk("midrst_state", 32'(fsm_state), 32'(IDLE));
    ps2d = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(20);
    clr_mon();
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("postrst_ready_cnt", 32'(rdy_cnt), 1);
    chk("postrst_code", 32'(last_code), 32'h1C);
    chk("postrst_brk", 32'(last_brk), 0);
    chk("postrst_err_cnt", 32'(err_cnt), 0);

    chk("ready_err_exclusive", 32'(both_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
- Upstream receive stage of the keyboard path.
- Samples the raw PS/2 clock/data lines and deframes 11-bit PS/2 frames into scan-code bytes.
- Flags break (F0) and extended (E0) prefixes.
- Delivers each byte to the keyboard master FSM as `scan_code` with a one-cycle `ready` strobe and a `brk_code` level.

Parameters:
- FILTER_LEN, 8: number of consecutive equal `ps2c` samples required to change the filtered clock level.
- TIMEOUT_CYC, 50000: clk cycles without a `ps2c` falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2c  in  1  raw PS/2 clock from the pin, asynchronous
- ps2d  in  1  raw PS/2 data from the pin, asynchronous
- rx_en  in  1  enables the start of new frames
- scan_code  out  8  last received byte, held until the next valid byte
- ready  out  1  one-cycle strobe: a valid byte is on `scan_code`
- brk_code  out  1  break-prefix level, see Behaviour
- ext_code  out  1  extended-prefix level, see Behaviour
- frame_err  out  1  one-cycle strobe: frame rejected (bad stop bit, bad parity, or timeout)

Behaviour:
- Reset (asynchronous, active-high): state IDLE; `scan_code`=8'h00; `ready`, `brk_code`, `ext_code`, `frame_err` all 0; shift register, bit counter and timeout counter cleared. Reset mid-frame discards the partial frame.
- Input conditioning:
  - `ps2c` and `ps2d` each pass through a 2-FF synchroniser.
  - Filtered clock changes level only after FILTER_LEN identical synchronised samples.
  - `fall_edge` is a one-cycle pulse on each filtered high-to-low transition.
  - Data is sampled from synchronised `ps2d` in the `fall_edge` cycle.
- FSM states: IDLE, RX, LOAD.
  - IDLE: on `fall_edge` && `rx_en` && `ps2d`==0 (start bit) -> RX, bit_cnt=9, timeout counter cleared. A start bit of 1, or `rx_en`=0, leaves the FSM in IDLE.
  - RX: each `fall_edge` shifts `ps2d` into a 10-bit register MSB-first from the top (8 data bits LSB-first, then parity, then stop), decrements bit_cnt, and clears the timeout counter. On the edge with bit_cnt==0 -> LOAD.
  - RX timeout: timeout counter reaches TIMEOUT_CYC-1 with no edge -> IDLE, `frame_err` pulses. Edge and timeout in the same cycle: the edge wins.
  - `rx_en` dropping during RX does not abort; the frame completes.
  - LOAD (1 cycle) -> IDLE, with these checks:
    - stop==1 and odd parity correct: byte valid.
    - Otherwise: `frame_err` pulses, no `ready`, prefix flags unchanged.
- Valid byte handling:
  - `scan_code` <= byte and `ready`=1 for exactly one cycle, 2 clk cycles after the `fall_edge` cycle that carried the stop bit.
  - `ready` fires for every valid byte, including F0 and E0.
- Prefix flags:
  - Byte F0: `brk_code` rises in the same cycle as its `ready`.
  - Byte E0: `ext_code` rises in the same cycle as its `ready`.
  - Both flags stay high through the `ready` cycle of the next non-prefix byte and clear on the following cycle.
  - Sequence E0,F0,xx: both flags are high at xx's `ready`.
  - A repeated F0 keeps `brk_code` high.
- Output `ready` and `frame_err` are mutually exclusive.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the odd-parity check is part of LOAD validation, and a parity failure rejects the byte with a `frame_err` pulse.
- Undefined: the parity bit is shifted in but ignored; only the stop bit and timeout can cause `frame_err`.

Decomposition:
- Shared keyboard package holds:
  - state encoding constants IDLE/RX/LOAD;
  - SC_BREAK=8'hF0, SC_EXT=8'hE0;
  - FRAME_BITS=11.
- One sub-module: `ps2_clk_filter`, containing the 2-FF synchronisers, the FILTER_LEN glitch filter and `fall_edge` generation. Output: filtered clock, `fall_edge`, synchronised data.

Test Plan:
- Frame 0x1C (start0, data LSB-first, parity 0, stop1) with `rx_en`=1 -> one `ready` pulse, `scan_code`=8'h1C, `brk_code`=0, `ext_code`=0, `frame_err`=0.
- Frames F0 then 1C -> first `ready` with `scan_code`=F0 and `brk_code`=1; second `ready` with `scan_code`=1C and `brk_code`=1; `brk_code`=0 one cycle later.
- Frames E0,F0,75 -> at 75's `ready` both `ext_code` and `brk_code`=1; both 0 the next cycle.
- 0x1C frame with parity bit flipped, macro defined -> `frame_err` pulse, no `ready`, `scan_code` unchanged. Same frame, macro undefined -> `ready`, `scan_code`=1C.
- 5 bits sent then `ps2c` held high for TIMEOUT_CYC cycles -> `frame_err` pulse, FSM back in IDLE; a following valid 0x2D frame -> `ready`, `scan_code`=2D.
- 2-cycle glitch pulses on `ps2c` (FILTER_LEN=8) -> no `fall_edge`, no state change. Reset asserted mid-frame -> all outputs 0, IDLE; the next full frame is received correctly.
